// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline definitions: arbiter state encodings, the NOP used for
// aborted fetches, and a width helper for the data-streak counter.
package riscv_pipe_pkg;

    localparam logic [1:0]  ST_IDLE   = 2'd0;
    localparam logic [1:0]  ST_BUSY_I = 2'd1;
    localparam logic [1:0]  ST_BUSY_D = 2'd2;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // A zero streak limit still needs a one-bit counter to keep widths legal.
    function automatic int streakWidth(input int maxStreak);
        return (maxStreak > 0) ? $clog2(maxStreak + 1) : 1;
    endfunction

endpackage

// File: rtl/arb_timeout_timer.sv
// Busy-cycle watchdog for the memory port arbiter: reloaded on every grant,
// counts cycles spent waiting on mem_ready and flags expiry on the TIMEOUT-th one.
module arb_timeout_timer #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic i_load,
    input  logic i_count,
    output logic o_expire
);

    localparam int              CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_count;

    assign o_expire = i_count && (r_count == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= '0;
        end else if (i_count && !o_expire) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch (read-only) and data (load/store),
// data first with a streak guard against fetch starvation. Define ARB_TIMEOUT_EN for the busy watchdog.
module mem_port_arbiter
    import riscv_pipe_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int MAX_D_STREAK = 4,
    parameter int TIMEOUT      = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_if_req,
    input  logic [ADDR_W-1:0] i_if_addr,
    output logic [31:0]       o_if_rdata,
    output logic              o_if_valid,
    input  logic              i_dm_req,
    input  logic              i_dm_we,
    input  logic [ADDR_W-1:0] i_dm_addr,
    input  logic [31:0]       i_dm_wdata,
    output logic [31:0]       o_dm_rdata,
    output logic              o_dm_valid,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    input  logic [31:0]       i_mem_rdata,
    input  logic              i_mem_ready,
    output logic              o_stall_f,
    output logic              o_stall_m,
    output logic              o_err
);

    localparam int                  STREAK_W   = streakWidth(MAX_D_STREAK);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

    logic [1:0]          r_state;
    logic                r_if_valid;
    logic                r_dm_valid;
    logic [31:0]         r_if_rdata;
    logic [31:0]         r_dm_rdata;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [31:0]         r_mem_wdata;
    logic [STREAK_W-1:0] r_streak;

    logic w_idle;
    logic w_busy;
    logic w_if_elig;
    logic w_dm_elig;
    logic w_can_grant;
    logic w_guard;
    logic w_grant_d;
    logic w_grant_i;
    logic w_timeout;
    logic w_done;

    assign w_idle    = (r_state == ST_IDLE);
    assign w_busy    = ~w_idle;
    assign w_if_elig = i_if_req & ~r_if_valid;
    assign w_dm_elig = i_dm_req & ~r_dm_valid;

    // The completion-pulse cycle is the mandatory gap between transactions.
    assign w_can_grant = w_idle & ~r_if_valid & ~r_dm_valid;
    assign w_guard     = (MAX_D_STREAK != 0) && (r_streak == STREAK_MAX);
    assign w_grant_d   = w_can_grant & w_dm_elig & ~(w_if_elig & w_guard);
    assign w_grant_i   = w_can_grant & w_if_elig & ~w_grant_d;
    assign w_done      = w_busy & (i_mem_ready | w_timeout);

`ifdef ARB_TIMEOUT_EN
    logic r_err;

    arb_timeout_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .i_load   (w_grant_d | w_grant_i),
        .i_count  (w_busy & ~i_mem_ready),
        .o_expire (w_timeout)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_timeout;
        end
    end

    assign o_err = r_err;
`else
    assign w_timeout = 1'b0;
    assign o_err     = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_if_valid  <= 1'b0;
            r_dm_valid  <= 1'b0;
            r_if_rdata  <= '0;
            r_dm_rdata  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_if_valid <= 1'b0;
            r_dm_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_d) begin
                        r_state     <= ST_BUSY_D;
                        r_mem_we    <= i_dm_we;
                        r_mem_addr  <= i_dm_addr;
                        r_mem_wdata <= i_dm_wdata;
                    end else if (w_grant_i) begin
                        r_state    <= ST_BUSY_I;
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= i_if_addr;
                    end
                end
                ST_BUSY_I: begin
                    if (w_done) begin
                        r_state    <= ST_IDLE;
                        r_if_valid <= 1'b1;
                        r_if_rdata <= w_timeout ? NOP_INSTR : i_mem_rdata;
                    end
                end
                ST_BUSY_D: begin
                    if (w_done) begin
                        r_state    <= ST_IDLE;
                        r_dm_valid <= 1'b1;
                        if (!r_mem_we) begin
                            r_dm_rdata <= w_timeout ? 32'h0 : i_mem_rdata;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Streak only grows while fetch is actually being passed over.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_streak <= '0;
        end else if (w_grant_i) begin
            r_streak <= '0;
        end else if (w_idle && !i_if_req) begin
            r_streak <= '0;
        end else if (w_grant_d && w_if_elig && (r_streak != STREAK_MAX)) begin
            r_streak <= r_streak + 1'b1;
        end
    end

    assign o_mem_req   = w_busy;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_if_valid  = r_if_valid;
    assign o_if_rdata  = r_if_rdata;
    assign o_dm_valid  = r_dm_valid;
    assign o_dm_rdata  = r_dm_rdata;
    assign o_stall_f   = i_if_req & ~r_if_valid;
    assign o_stall_m   = i_dm_req & ~r_dm_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; inputs change and outputs are sampled on the falling edge.
// Builds with or without ARB_TIMEOUT_EN and exercises the matching timeout behaviour.
module tb_mem_port_arbiter;
    import riscv_pipe_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        ifReq;
    logic [31:0] ifAddr;
    logic [31:0] ifRdata;
    logic        ifValid;
    logic        dmReq;
    logic        dmWe;
    logic [31:0] dmAddr;
    logic [31:0] dmWdata;
    logic [31:0] dmRdata;
    logic        dmValid;
    logic        memReq;
    logic        memWe;
    logic [31:0] memAddr;
    logic [31:0] memWdata;
    logic [31:0] memRdata;
    logic        memReady;
    logic        stallF;
    logic        stallM;
    logic        err;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] lastDm   = 32'h0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W       (32),
        .MAX_D_STREAK (4),
        .TIMEOUT      (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .i_if_req    (ifReq),
        .i_if_addr   (ifAddr),
        .o_if_rdata  (ifRdata),
        .o_if_valid  (ifValid),
        .i_dm_req    (dmReq),
        .i_dm_we     (dmWe),
        .i_dm_addr   (dmAddr),
        .i_dm_wdata  (dmWdata),
        .o_dm_rdata  (dmRdata),
        .o_dm_valid  (dmValid),
        .o_mem_req   (memReq),
        .o_mem_we    (memWe),
        .o_mem_addr  (memAddr),
        .o_mem_wdata (memWdata),
        .i_mem_rdata (memRdata),
        .i_mem_ready (memReady),
        .o_stall_f   (stallF),
        .o_stall_m   (stallM),
        .o_err       (err)
    );

    task automatic test_reset();
        reset = 1'b1; ifReq = 0; ifAddr = 0; dmReq = 0; dmWe = 0; dmAddr = 0;
        dmWdata = 0; memRdata = 0; memReady = 0;
        repeat (2) @(negedge clk);
        checks++;
        if ({memReq, memWe, ifValid, dmValid, err, stallF, stallM} !== 7'b0) begin
            failures++;
            $display("[TB] FAIL reset_flags got=%b exp=0000000",
                     {memReq, memWe, ifValid, dmValid, err, stallF, stallM});
        end
        checks++;
        if (memAddr !== 32'h0 || ifRdata !== 32'h0 || dmRdata !== 32'h0 || memWdata !== 32'h0) begin
            failures++;
            $display("[TB] FAIL reset_data got addr=%h if=%h dm=%h wd=%h exp all 0",
                     memAddr, ifRdata, dmRdata, memWdata);
        end
        reset = 1'b0;
    endtask

    task automatic test_fetch_only();
        @(negedge clk);
        ifReq = 1; ifAddr = 32'h10;
        #1;
        checks++;
        if (stallF !== 1'b1) begin failures++; $display("[TB] FAIL fetch_stall_c0 got=%b exp=1", stallF); end
        @(negedge clk);
        checks++;
        if (memReq !== 1'b1 || memAddr !== 32'h10 || memWe !== 1'b0) begin
            failures++;
            $display("[TB] FAIL fetch_grant got req=%b addr=%h we=%b exp 1/00000010/0", memReq, memAddr, memWe);
        end
        checks++;
        if (stallF !== 1'b1 || ifValid !== 1'b0) begin
            failures++; $display("[TB] FAIL fetch_c1 got stall=%b valid=%b exp 1/0", stallF, ifValid);
        end
        memReady = 1; memRdata = 32'h0050_0093;
        @(negedge clk);
        checks++;
        if (ifValid !== 1'b1 || ifRdata !== 32'h0050_0093 || stallF !== 1'b0 || memReq !== 1'b0) begin
            failures++;
            $display("[TB] FAIL fetch_done got valid=%b data=%h stall=%b req=%b exp 1/00500093/0/0",
                     ifValid, ifRdata, stallF, memReq);
        end
        ifReq = 0; memReady = 0; memRdata = 0;
        @(negedge clk);
        checks++;
        if (ifValid !== 1'b0) begin failures++; $display("[TB] FAIL fetch_pulse_width got=%b exp=0", ifValid); end
    endtask

    task automatic test_priority();
        @(negedge clk);
        ifReq = 1; ifAddr = 32'h20; dmReq = 1; dmWe = 0; dmAddr = 32'h40;
        @(negedge clk);
        checks++;
        if (memReq !== 1'b1 || memAddr !== 32'h40 || memWe !== 1'b0) begin
            failures++;
            $display("[TB] FAIL prio_data_first got req=%b addr=%h we=%b exp 1/00000040/0", memReq, memAddr, memWe);
        end
        memReady = 1; memRdata = 32'h1111_2222;
        @(negedge clk);
        checks++;
        if (dmValid !== 1'b1 || dmRdata !== 32'h1111_2222 || stallM !== 1'b0 || stallF !== 1'b1) begin
            failures++;
            $display("[TB] FAIL prio_data_done got valid=%b data=%h stallM=%b stallF=%b exp 1/11112222/0/1",
                     dmValid, dmRdata, stallM, stallF);
        end
        lastDm = 32'h1111_2222;
        dmReq = 0; memReady = 0;
        @(negedge clk);
        checks++;
        if (memReq !== 1'b0) begin failures++; $display("[TB] FAIL prio_idle_gap got req=%b exp=0", memReq); end
        @(negedge clk);
        checks++;
        if (memReq !== 1'b1 || memAddr !== 32'h20) begin
            failures++; $display("[TB] FAIL prio_fetch_next got req=%b addr=%h exp 1/00000020", memReq, memAddr);
        end
        memReady = 1; memRdata = 32'h00A0_0113;
        @(negedge clk);
        checks++;
        if (ifValid !== 1'b1 || ifRdata !== 32'h00A0_0113) begin
            failures++; $display("[TB] FAIL prio_fetch_done got valid=%b data=%h exp 1/00a00113", ifValid, ifRdata);
        end
        ifReq = 0; memReady = 0;
    endtask

    task automatic test_streak_guard();
        logic [31:0] expAddr [6];
        expAddr = '{32'h100, 32'h100, 32'h100, 32'h100, 32'h30, 32'h100};
        @(negedge clk);
        ifReq = 1; ifAddr = 32'h30; dmReq = 1; dmWe = 0; dmAddr = 32'h100;
        for (int g = 0; g < 6; g++) begin
            int          waitCnt;
            logic [31:0] word;
            waitCnt = 0;
            word    = 32'hA000_0000 + 32'(g);
            @(negedge clk);
            while (memReq !== 1'b1 && waitCnt < 8) begin
                @(negedge clk);
                waitCnt++;
            end
            checks++;
            if (memAddr !== expAddr[g] || memReq !== 1'b1) begin
                failures++;
                $display("[TB] FAIL streak_order[%0d] got req=%b addr=%h exp 1/%h", g, memReq, memAddr, expAddr[g]);
            end
            if (g == 3) begin
                checks++;
                if (dut.r_streak !== 4) begin failures++; $display("[TB] FAIL streak_full got=%0d exp=4", dut.r_streak); end
            end
            if (g == 4) begin
                checks++;
                if (dut.r_streak !== 0) begin failures++; $display("[TB] FAIL streak_clear got=%0d exp=0", dut.r_streak); end
            end
            memReady = 1; memRdata = word;
            @(negedge clk);
            memReady = 0;
            checks++;
            if (expAddr[g] == 32'h30) begin
                if (ifValid !== 1'b1 || ifRdata !== word || dmValid !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL streak_fetch_done[%0d] got valid=%b data=%h dmv=%b exp 1/%h/0",
                             g, ifValid, ifRdata, dmValid, word);
                end
            end else begin
                if (dmValid !== 1'b1 || dmRdata !== word || ifValid !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL streak_data_done[%0d] got valid=%b data=%h ifv=%b exp 1/%h/0",
                             g, dmValid, dmRdata, ifValid, word);
                end
                lastDm = word;
            end
        end
        ifReq = 0; dmReq = 0;
    endtask

    task automatic test_store();
        @(negedge clk);
        dmReq = 1; dmWe = 1; dmAddr = 32'h80; dmWdata = 32'hCAFE_F00D;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            checks++;
            if (memReq !== 1'b1 || memWe !== 1'b1 || memWdata !== 32'hCAFE_F00D ||
                memAddr !== 32'h80 || dmValid !== 1'b0) begin
                failures++;
                $display("[TB] FAIL store_hold[%0d] got req=%b we=%b wd=%h addr=%h v=%b exp 1/1/cafef00d/00000080/0",
                         c, memReq, memWe, memWdata, memAddr, dmValid);
            end
            if (c == 6) begin memReady = 1; memRdata = 32'hDEAD_BEEF; end
        end
        @(negedge clk);
        checks++;
        if (dmValid !== 1'b1 || dmRdata !== lastDm || stallM !== 1'b0) begin
            failures++;
            $display("[TB] FAIL store_done got valid=%b data=%h stallM=%b exp 1/%h/0", dmValid, dmRdata, stallM, lastDm);
        end
        dmReq = 0; dmWe = 0; memReady = 0; memRdata = 0;
    endtask

    task automatic test_reset_busy();
        @(negedge clk);
        dmReq = 1; dmWe = 0; dmAddr = 32'h44;
        @(negedge clk);
        checks++;
        if (memReq !== 1'b1) begin failures++; $display("[TB] FAIL rst_busy_pre got req=%b exp=1", memReq); end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (memReq !== 1'b0 || dut.r_state !== ST_IDLE) begin
            failures++; $display("[TB] FAIL rst_async got req=%b state=%0d exp 0/0", memReq, dut.r_state);
        end
        dmReq = 0;
        @(negedge clk);
        reset = 1'b0; memReady = 1; memRdata = 32'h0000_0099;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (dmValid !== 1'b0 || ifValid !== 1'b0 || memReq !== 1'b0 || dmRdata !== 32'h0) begin
                failures++;
                $display("[TB] FAIL rst_late_ready[%0d] got dv=%b iv=%b req=%b data=%h exp 0/0/0/0",
                         c, dmValid, ifValid, memReq, dmRdata);
            end
        end
        memReady = 0; memRdata = 0;
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        @(negedge clk);
        ifReq = 1; ifAddr = 32'h50;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            checks++;
            if (memReq !== 1'b1 || ifValid !== 1'b0 || err !== 1'b0) begin
                failures++;
                $display("[TB] FAIL timeout_wait[%0d] got req=%b v=%b err=%b exp 1/0/0", c, memReq, ifValid, err);
            end
        end
        @(negedge clk);
        checks++;
        if (ifValid !== 1'b1 || ifRdata !== 32'h0000_0013 || err !== 1'b1 || memReq !== 1'b0) begin
            failures++;
            $display("[TB] FAIL timeout_fire got v=%b data=%h err=%b req=%b exp 1/00000013/1/0",
                     ifValid, ifRdata, err, memReq);
        end
        ifReq = 0;
        @(negedge clk);
        checks++;
        if (err !== 1'b0 || dut.r_state !== ST_IDLE) begin
            failures++; $display("[TB] FAIL timeout_after got err=%b state=%0d exp 0/0", err, dut.r_state);
        end
    endtask
`else
    task automatic test_timeout();
        @(negedge clk);
        ifReq = 1; ifAddr = 32'h50;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            checks++;
            if (memReq !== 1'b1 || ifValid !== 1'b0 || err !== 1'b0) begin
                failures++;
                $display("[TB] FAIL no_timeout_wait[%0d] got req=%b v=%b err=%b exp 1/0/0", c, memReq, ifValid, err);
            end
        end
        memReady = 1; memRdata = 32'h0001_3579;
        @(negedge clk);
        checks++;
        if (ifValid !== 1'b1 || ifRdata !== 32'h0001_3579 || err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL no_timeout_done got v=%b data=%h err=%b exp 1/00013579/0", ifValid, ifRdata, err);
        end
        ifReq = 0; memReady = 0;
    endtask
`endif

    initial begin
        test_reset();
        test_fetch_only();
        test_priority();
        test_streak_guard();
        test_store();
        test_reset_busy();
        test_timeout();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
